// File: rtl/leve_axi_pkg.sv
// rtl/leve_axi_pkg.sv - shared types and helpers for the AXI read target
package leve_axi_pkg;

  localparam int ARLEN_W = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  function automatic logic wrap_len_ok(input logic [ARLEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // WRAP with an unsupported length and the reserved encoding both behave as INCR.
  function automatic burst_e decode_burst(input logic [1:0] b, input logic [ARLEN_W-1:0] len);
    burst_e r;
    case (b)
      2'b00:   r = BURST_FIXED;
      2'b10:   r = wrap_len_ok(len) ? BURST_WRAP : BURST_INCR;
      default: r = BURST_INCR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/leve_sram.sv
// rtl/leve_sram.sv - 1R1W synchronous RAM, gated read, old data on collision
module leve_sram #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/leve_axir_target.sv
// rtl/leve_axir_target.sv - AXI4 read responder over a preloadable word memory
module leve_axir_target
  import leve_axi_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic [1:0]            ARBURST,
  input  logic [ARLEN_W-1:0]    ARLEN,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  RLAST,
  input  logic                  LD_WE,
  input  logic [DEPTH_LOG2-1:0] LD_ADDR,
  input  logic [DATA_W-1:0]     LD_DATA
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  state_e                state_q, state_d;
  burst_e                burst_q, burst_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d, next_idx, wrap_mask;
  logic [ARLEN_W-1:0]    len_q, len_d;
  logic [ARLEN_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [ARLEN_W-1:0]    hs_cnt_q, hs_cnt_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  issue;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{ARADDR[ADDR_W-1:DEPTH_LOG2+OFF_W], ARADDR[OFF_W-1:0]};

  // WRAP only advances the low log2(len+1) index bits; the block base stays put.
  assign wrap_mask = DEPTH_LOG2'(len_q[3:0]);

  always_comb begin
    case (burst_q)
      BURST_FIXED: next_idx = idx_q;
      BURST_WRAP:  next_idx = (idx_q & ~wrap_mask) | ((idx_q + DEPTH_LOG2'(1)) & wrap_mask);
      default:     next_idx = idx_q + DEPTH_LOG2'(1);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    idx_d       = idx_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    hs_cnt_d    = hs_cnt_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    issue       = 1'b0;

    if (rvalid_q && RREADY) hs_cnt_d = hs_cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          arready_d   = 1'b0;
          idx_d       = ARADDR[DEPTH_LOG2+OFF_W-1:OFF_W];
          len_d       = ARLEN;
          burst_d     = decode_burst(ARBURST, ARLEN);
          issue_cnt_d = '0;
          hs_cnt_d    = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!rvalid_q || RREADY) begin
          issue       = 1'b1;
          rvalid_d    = 1'b1;
          rlast_d     = (issue_cnt_q == len_q);
          issue_cnt_d = issue_cnt_q + 8'd1;
          idx_d       = next_idx;
          if (issue_cnt_q == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rvalid_q && RREADY && (hs_cnt_q == len_q)) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      burst_q     <= BURST_INCR;
      idx_q       <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      hs_cnt_q    <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      hs_cnt_q    <= hs_cnt_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
    end
  end

  leve_sram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk   (CLK),
    .rst   (RST),
    .re    (issue),
    .raddr (idx_q),
    .we    (LD_WE),
    .waddr (LD_ADDR),
    .wdata (LD_DATA),
    .rdata (RDATA)
  );

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_leve_axir_target.sv
// tb/tb_leve_axir_target.sv - randomized self-checking bench for leve_axir_target
module tb_leve_axir_target;

  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 12;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                  clk;
  logic                  rst;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [1:0]            arburst;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic                  rlast;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [DATA_W-1:0]     ld_data;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mem_m [DEPTH];

  leve_axir_target #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .ARVALID (arvalid),
    .ARREADY (arready),
    .ARADDR  (araddr),
    .ARBURST (arburst),
    .ARLEN   (arlen),
    .RVALID  (rvalid),
    .RREADY  (rready),
    .RDATA   (rdata),
    .RLAST   (rlast),
    .LD_WE   (ld_we),
    .LD_ADDR (ld_addr),
    .LD_DATA (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Word index touched by beat i of a burst, straight from the burst rules.
  function automatic int beat_word(input int start, input logic [1:0] burst, input int len, input int i);
    int n;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      n = len + 1;
      return (start - (start % n)) + ((start % n) + i) % n;
    end
    return (start + i) % DEPTH;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    ld_we   = 1'b1;
    ld_addr = DEPTH_LOG2'(idx);
    ld_data = val;
    mem_m[idx] = val;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // mode 0: RREADY always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random.
  task automatic run_burst(input logic [63:0] addr, input logic [1:0] burst, input int len,
                           input int mode, input bit hold_ar);
    logic [31:0] exp_q[$];
    int start, beat, cyc, w;
    bit rr;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    start = int'((addr / 64'd4) % 64'(DEPTH));
    for (int i = 0; i <= len; i++) exp_q.push_back(mem_m[beat_word(start, burst, len, i)]);
    w = 0;
    while (!arready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!arready) begin
      chk("ar_accept_timeout", 0, 1);
      return;
    end
    arvalid = 1'b1;
    araddr  = addr;
    arburst = burst;
    arlen   = 8'(len);
    rready  = 1'b1;
    @(negedge clk);
    if (!hold_ar) arvalid = 1'b0;
    chk("t1_rvalid", 64'(rvalid), 0);
    chk("t1_arready", 64'(arready), 0);
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (mode == 0) chk("stream_rvalid", 64'(rvalid), 1);
      chk("busy_arready", 64'(arready), 0);
      case (mode)
        0:       rr = 1'b1;
        1:       rr = pat[cyc % 6];
        default: rr = 1'($urandom % 2);
      endcase
      rready = rr;
      if (rvalid) begin
        chk($sformatf("rdata_b%0d", beat), 64'(rdata), 64'(exp_q[beat]));
        chk($sformatf("rlast_b%0d", beat), 64'(rlast), 64'(beat == len));
        if (rr) beat++;
      end
    end
    if (beat <= len) chk("burst_timeout", 64'(beat), 64'(len + 1));
    @(negedge clk);
    chk("end_rvalid", 64'(rvalid), 0);
    chk("end_arready", 64'(arready), 1);
  endtask

  initial begin
    rst     = 1'b1;
    arvalid = 1'b0;
    araddr  = '0;
    arburst = 2'b01;
    arlen   = '0;
    rready  = 1'b0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    @(negedge clk);
    chk("rst_arready", 64'(arready), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_rlast", 64'(rlast), 0);
    chk("rst_rdata", 64'(rdata), 0);

    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = $urandom;
      ld_we    = 1'b1;
      ld_addr  = DEPTH_LOG2'(i);
      ld_data  = mem_m[i];
      @(negedge clk);
    end
    ld_we = 1'b0;
    for (int i = 0; i < 16; i++) preload(i, 32'h1000 + 32'(i));

    chk("rst_hold_arready", 64'(arready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", 64'(arready), 1);

    run_burst(64'h10, 2'b01, 3, 0, 1'b0);
    run_burst(64'h18, 2'b10, 3, 0, 1'b0);
    run_burst(64'h0, 2'b01, 7, 1, 1'b0);
    run_burst(64'h8, 2'b00, 2, 0, 1'b0);
    run_burst(64'h24, 2'b01, 0, 0, 1'b0);
    run_burst(64'hABCD_0000_0000_3FFC, 2'b01, 1, 0, 1'b0);
    run_burst(64'h1C, 2'b10, 2, 0, 1'b0);
    run_burst(64'h2C, 2'b11, 4, 2, 1'b0);
    run_burst(64'h34, 2'b10, 7, 2, 1'b0);
    run_burst(64'h3C, 2'b01, 3, 0, 1'b1);
    run_burst(64'h3C, 2'b01, 3, 0, 1'b0);
    run_burst(64'h100, 2'b01, 255, 2, 1'b0);

    // Reset in the middle of an 8-beat burst.
    while (!arready) @(negedge clk);
    arvalid = 1'b1;
    araddr  = 64'h0;
    arburst = 2'b01;
    arlen   = 8'd7;
    rready  = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_rvalid", 64'(rvalid), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_rvalid", 64'(rvalid), 0);
    chk("abort_rlast", 64'(rlast), 0);
    chk("abort_rdata", 64'(rdata), 0);
    chk("abort_arready", 64'(arready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_release_arready", 64'(arready), 1);
    run_burst(64'h8, 2'b01, 7, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [63:0] a;
      int          ln;
      if (k % 5 == 0) preload(int'($urandom % DEPTH), $urandom);
      a  = {$urandom, $urandom};
      ln = (k % 7 == 0) ? int'($urandom_range(16, 40)) : int'($urandom_range(0, 15));
      run_burst(a, 2'($urandom % 4), ln, int'($urandom % 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
